// File: rtl/axi_pkg.sv
// Shared AXI encodings, slave FSM states and the burst-context record used by sram_axi_slave.
package axi_pkg;

   localparam int CTX_ID_W   = 8;
   localparam int CTX_ADDR_W = 14;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [2:0] SIZE_WORD = 3'b010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      R_DATA = 2'd1,
      W_DATA = 2'd2,
      B_RESP = 2'd3
   } slv_state_t;

   typedef struct packed {
      logic [CTX_ID_W-1:0]   id;
      logic [CTX_ADDR_W-1:0] addr;
      logic [3:0]            len;
      logic [1:0]            burst;
      logic [3:0]            cnt;
      logic                  err;
   } burst_ctx_t;

   // WRAP bursts deliberately fall through to incrementing behaviour.
   function automatic logic [CTX_ADDR_W-1:0] next_addr(input logic [CTX_ADDR_W-1:0] addr,
                                                       input logic [1:0]            burst);
      return (burst == BURST_FIXED) ? addr : addr + CTX_ADDR_W'(1);
   endfunction

endpackage

// File: rtl/sram_axi_slave_if.sv
// AXI4 bus bundle between the interconnect (master side) and the SRAM slave wrapper.
interface sram_axi_slave_if #(
   parameter int ID_W   = 8,
   parameter int DATA_W = 32
);
   logic [ID_W-1:0]     AWID;
   logic [31:0]         AWADDR;
   logic [3:0]          AWLEN;
   logic [2:0]          AWSIZE;
   logic [1:0]          AWBURST;
   logic                AWVALID;
   logic                AWREADY;

   logic [DATA_W-1:0]   WDATA;
   logic [DATA_W/8-1:0] WSTRB;
   logic                WLAST;
   logic                WVALID;
   logic                WREADY;

   logic [ID_W-1:0]     BID;
   logic [1:0]          BRESP;
   logic                BVALID;
   logic                BREADY;

   logic [ID_W-1:0]     ARID;
   logic [31:0]         ARADDR;
   logic [3:0]          ARLEN;
   logic [2:0]          ARSIZE;
   logic [1:0]          ARBURST;
   logic                ARVALID;
   logic                ARREADY;

   logic [ID_W-1:0]     RID;
   logic [DATA_W-1:0]   RDATA;
   logic [1:0]          RRESP;
   logic                RLAST;
   logic                RVALID;
   logic                RREADY;

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY,
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY
   );

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY
   );
endinterface

// File: rtl/sram_axi_slave.sv
// AXI4 slave front-end for one single-port SRAM macro: one transaction at a time,
// INCR/FIXED bursts of 1-16 words, SRAM access issued in the same cycle as the handshake.
module sram_axi_slave
   import axi_pkg::*;
#(
   parameter int ID_W   = CTX_ID_W,
   parameter int ADDR_W = CTX_ADDR_W,
   parameter int DATA_W = 32
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   sram_axi_slave_if.slave   s_axi,
   output logic              sram_ceb,
   output logic              sram_web,
   output logic [DATA_W-1:0] sram_bweb,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_di,
   input  logic [DATA_W-1:0] sram_do
);

   if (ID_W != CTX_ID_W || ADDR_W != CTX_ADDR_W) begin : g_bad_param
      $error("sram_axi_slave: ID_W/ADDR_W must match the axi_pkg context widths");
   end

   slv_state_t        r_state;
   slv_state_t        w_state_next;
   burst_ctx_t        r_ctx;
   burst_ctx_t        w_ctx_next;
   logic              r_alive;
   logic              r_first;
   logic              w_first_next;
   logic [DATA_W-1:0] r_hold;
   logic [ADDR_W-1:0] w_addr_adv;
   logic [DATA_W-1:0] w_bmask;
   logic              w_rlast;
   logic              w_beat_last;
   logic              w_unused;

   assign w_unused = ^{s_axi.ARADDR[31:ADDR_W+2], s_axi.ARADDR[1:0],
                       s_axi.AWADDR[31:ADDR_W+2], s_axi.AWADDR[1:0]};

   genvar gi;
   for (gi = 0; gi < DATA_W/8; gi++) begin : g_bmask
      assign w_bmask[gi*8 +: 8] = {8{~s_axi.WSTRB[gi]}};
   end

   assign w_addr_adv  = next_addr(r_ctx.addr, r_ctx.burst);
   assign w_rlast     = (r_ctx.cnt == r_ctx.len);
   assign w_beat_last = (r_ctx.cnt == r_ctx.len);

   // The SRAM output is only trustworthy the cycle after a read; afterwards RDATA replays r_hold.
   assign s_axi.RDATA = r_first ? sram_do : r_hold;
   assign s_axi.RID   = r_ctx.id;
   assign s_axi.BID   = r_ctx.id;
   assign s_axi.RRESP = (r_state == R_DATA && r_ctx.err) ? RESP_SLVERR : RESP_OKAY;
   assign s_axi.BRESP = (r_state == B_RESP && r_ctx.err) ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state <= IDLE;
         r_ctx   <= '0;
         r_alive <= 1'b0;
         r_first <= 1'b0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_next;
         r_ctx   <= w_ctx_next;
         r_alive <= 1'b1;
         r_first <= w_first_next;
         if (r_first) begin
            r_hold <= sram_do;
         end
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_ctx_next    = r_ctx;
      w_first_next  = 1'b0;
      s_axi.ARREADY = 1'b0;
      s_axi.AWREADY = 1'b0;
      s_axi.WREADY  = 1'b0;
      s_axi.RVALID  = 1'b0;
      s_axi.RLAST   = 1'b0;
      s_axi.BVALID  = 1'b0;
      sram_ceb      = 1'b1;
      sram_web      = 1'b1;
      sram_bweb     = '1;
      sram_a        = '0;
      sram_di       = '0;

      case (r_state)
         IDLE: begin
            // r_alive keeps the READYs low until the first clock after reset release.
            if (r_alive) begin
               s_axi.ARREADY = 1'b1;
               s_axi.AWREADY = ~s_axi.ARVALID;
               if (s_axi.ARVALID) begin
                  w_ctx_next.id    = s_axi.ARID;
                  w_ctx_next.addr  = s_axi.ARADDR[ADDR_W+1:2];
                  w_ctx_next.len   = s_axi.ARLEN;
                  w_ctx_next.burst = s_axi.ARBURST;
                  w_ctx_next.cnt   = 4'd0;
                  w_ctx_next.err   = (s_axi.ARSIZE != SIZE_WORD);
                  sram_ceb         = 1'b0;
                  sram_a           = s_axi.ARADDR[ADDR_W+1:2];
                  w_first_next     = 1'b1;
                  w_state_next     = R_DATA;
               end else if (s_axi.AWVALID) begin
                  w_ctx_next.id    = s_axi.AWID;
                  w_ctx_next.addr  = s_axi.AWADDR[ADDR_W+1:2];
                  w_ctx_next.len   = s_axi.AWLEN;
                  w_ctx_next.burst = s_axi.AWBURST;
                  w_ctx_next.cnt   = 4'd0;
                  w_ctx_next.err   = (s_axi.AWSIZE != SIZE_WORD);
                  w_state_next     = W_DATA;
               end
            end
         end

         R_DATA: begin
            s_axi.RVALID = 1'b1;
            s_axi.RLAST  = w_rlast;
            if (s_axi.RREADY) begin
               if (!w_rlast) begin
                  sram_ceb        = 1'b0;
                  sram_a          = w_addr_adv;
                  w_ctx_next.addr = w_addr_adv;
                  w_ctx_next.cnt  = r_ctx.cnt + 4'd1;
                  w_first_next    = 1'b1;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end

         W_DATA: begin
            s_axi.WREADY = 1'b1;
            if (s_axi.WVALID) begin
               sram_ceb  = 1'b0;
               sram_web  = 1'b0;
               sram_a    = r_ctx.addr;
               sram_di   = s_axi.WDATA;
               sram_bweb = w_bmask;
               // Early or missing WLAST both terminate the burst but poison the response.
               if (s_axi.WLAST != w_beat_last) begin
                  w_ctx_next.err = 1'b1;
               end
               if (s_axi.WLAST || w_beat_last) begin
                  w_state_next = B_RESP;
               end else begin
                  w_ctx_next.addr = w_addr_adv;
                  w_ctx_next.cnt  = r_ctx.cnt + 4'd1;
               end
            end
         end

         B_RESP: begin
            s_axi.BVALID = 1'b1;
            if (s_axi.BREADY) begin
               w_state_next = IDLE;
            end
         end

         default: w_state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Scoreboard bench for sram_axi_slave: stimulus pushes expected R/B responses, a negedge monitor checks them.
module tb_sram_axi_slave;
   import axi_pkg::*;

   localparam int ID_W   = 8;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   sram_axi_slave_if #(.ID_W(ID_W), .DATA_W(DATA_W)) bus();

   logic              ceb;
   logic              web;
   logic [DATA_W-1:0] bweb;
   logic [ADDR_W-1:0] a;
   logic [DATA_W-1:0] di;
   logic [DATA_W-1:0] dout;

   sram_axi_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .ACLK     (clk),
      .ARESETn  (rstn),
      .s_axi    (bus),
      .sram_ceb (ceb),
      .sram_web (web),
      .sram_bweb(bweb),
      .sram_a   (a),
      .sram_di  (di),
      .sram_do  (dout)
   );

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   int wr_count = 0;

   always @(posedge clk) begin
      if (!ceb) begin
         if (!web) begin
            mem[a]   <= (mem[a] & bweb) | (di & ~bweb);
            wr_count <= wr_count + 1;
         end else begin
            dout <= mem[a];
         end
      end
   end

   typedef struct {
      logic [7:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rexp_t;

   typedef struct {
      logic [7:0] id;
      logic [1:0] resp;
   } bexp_t;

   rexp_t rq[$];
   bexp_t bq[$];
   rexp_t re;
   bexp_t be;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (bus.RVALID && bus.RREADY) begin
            check("r_expected", rq.size() != 0, 1);
            if (rq.size() != 0) begin
               re = rq.pop_front();
               check("rid", bus.RID, re.id);
               check("rdata", bus.RDATA, re.data);
               check("rresp", bus.RRESP, re.resp);
               check("rlast", bus.RLAST, re.last);
               $display("[TB] R beat id=%02h data=%08h last=%0d", bus.RID, bus.RDATA, bus.RLAST);
            end
         end
         if (bus.BVALID && bus.BREADY) begin
            check("b_expected", bq.size() != 0, 1);
            if (bq.size() != 0) begin
               be = bq.pop_front();
               check("bid", bus.BID, be.id);
               check("bresp", bus.BRESP, be.resp);
               $display("[TB] B resp id=%02h resp=%0d", bus.BID, bus.BRESP);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
      int n;
      bus.ARID    = id;
      bus.ARADDR  = addr;
      bus.ARLEN   = len;
      bus.ARSIZE  = SIZE_WORD;
      bus.ARBURST = BURST_INCR;
      bus.ARVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.ARREADY && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("arready", bus.ARREADY, 1);
      tick();
      bus.ARVALID = 1'b0;
   endtask

   task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
      int n;
      bus.AWID    = id;
      bus.AWADDR  = addr;
      bus.AWLEN   = len;
      bus.AWSIZE  = SIZE_WORD;
      bus.AWBURST = BURST_INCR;
      bus.AWVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.AWREADY && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("awready", bus.AWREADY, 1);
      tick();
      bus.AWVALID = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n;
      bus.WDATA  = data;
      bus.WSTRB  = strb;
      bus.WLAST  = last;
      bus.WVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.WREADY && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wready", bus.WREADY, 1);
      tick();
      bus.WVALID = 1'b0;
      bus.WLAST  = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain", rq.size() + bq.size(), 0);
      tick();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_arready"}, bus.ARREADY, 0);
      check({tag, "_awready"}, bus.AWREADY, 0);
      check({tag, "_wready"}, bus.WREADY, 0);
      check({tag, "_rvalid"}, bus.RVALID, 0);
      check({tag, "_bvalid"}, bus.BVALID, 0);
      check({tag, "_rlast"}, bus.RLAST, 0);
      check({tag, "_rdata"}, bus.RDATA, 0);
      check({tag, "_ids"}, {bus.RID, bus.BID, bus.RRESP, bus.BRESP}, 0);
      check({tag, "_ceb_web"}, {ceb, web}, 2'b11);
      check({tag, "_bweb"}, bweb, 32'hFFFF_FFFF);
      check({tag, "_a_di"}, {a, di}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wc;
      logic [31:0] d1;

      bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
      bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
      bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b1;
      bus.BREADY = 1'b1;

      mem[14'h0010] = 32'hDEAD_BEEF;
      mem[14'h0040] = 32'h1000_0000;
      mem[14'h0041] = 32'h1000_0001;
      mem[14'h0042] = 32'h1000_0002;
      mem[14'h0043] = 32'h1000_0003;
      mem[14'h0020] = 32'h1122_3344;
      mem[14'h0080] = 32'h0000_0000;
      mem[14'h0081] = 32'hFEED_FACE;
      mem[14'h00C0] = 32'hCAFE_F00D;
      mem[14'h00C1] = 32'h0000_0000;
      mem[14'h3FFF] = 32'hA5A5_0001;
      mem[14'h0000] = 32'h5A5A_0002;
      mem[14'h0100] = 32'h0000_0000;
      mem[14'h0101] = 32'h0000_0000;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst");
      @(posedge clk);
      #1 rstn = 1'b1;
      tick();
      tick();
      check("idle_arready", bus.ARREADY, 1);

      // single read
      rq.push_back('{8'h05, 32'hDEAD_BEEF, RESP_OKAY, 1'b1});
      ar_send(8'h05, 32'h0000_0040, 4'd0);
      check("single_rvalid_t1", bus.RVALID, 1);
      wait_drain();

      // INCR burst with a two-cycle stall on beat 1
      rq.push_back('{8'h21, 32'h1000_0000, RESP_OKAY, 1'b0});
      rq.push_back('{8'h21, 32'h1000_0001, RESP_OKAY, 1'b0});
      rq.push_back('{8'h21, 32'h1000_0002, RESP_OKAY, 1'b0});
      rq.push_back('{8'h21, 32'h1000_0003, RESP_OKAY, 1'b1});
      ar_send(8'h21, 32'h0000_0100, 4'd3);
      tick();
      bus.RREADY = 1'b0;
      @(negedge clk);
      d1 = bus.RDATA;
      check("stall_ceb", ceb, 1);
      tick();
      @(negedge clk);
      check("stall_rdata_stable", bus.RDATA, d1);
      check("stall_rvalid", bus.RVALID, 1);
      check("stall_ceb2", ceb, 1);
      check("stall_rlast", bus.RLAST, 0);
      tick();
      bus.RREADY = 1'b1;
      wait_drain();

      // byte-strobe write
      bq.push_back('{8'h33, RESP_OKAY});
      aw_send(8'h33, 32'h0000_0080, 4'd0);
      w_send(32'hAABB_CCDD, 4'b0101, 1'b1);
      wait_drain();
      check("strb_mem", mem[14'h0020], 32'h11BB_33DD);

      // early WLAST on a two-beat burst
      wc = wr_count;
      bq.push_back('{8'h44, RESP_SLVERR});
      aw_send(8'h44, 32'h0000_0200, 4'd1);
      w_send(32'h0BAD_F00D, 4'hF, 1'b1);
      wait_drain();
      check("early_wlast_writes", wr_count - wc, 1);
      check("early_wlast_mem0", mem[14'h0080], 32'h0BAD_F00D);
      check("early_wlast_mem1", mem[14'h0081], 32'hFEED_FACE);

      // simultaneous AR and AW, then held B
      bus.BREADY = 1'b0;
      rq.push_back('{8'h55, 32'hCAFE_F00D, RESP_OKAY, 1'b1});
      bq.push_back('{8'h66, RESP_OKAY});
      bus.ARID = 8'h55; bus.ARADDR = 32'h0000_0300; bus.ARLEN = 4'd0;
      bus.ARSIZE = SIZE_WORD; bus.ARBURST = BURST_INCR; bus.ARVALID = 1'b1;
      bus.AWID = 8'h66; bus.AWADDR = 32'h0000_0304; bus.AWLEN = 4'd0;
      bus.AWSIZE = SIZE_WORD; bus.AWBURST = BURST_INCR; bus.AWVALID = 1'b1;
      @(negedge clk);
      check("both_arready", bus.ARREADY, 1);
      check("both_awready", bus.AWREADY, 0);
      tick();
      bus.ARVALID = 1'b0;
      @(negedge clk);
      check("busy_awready", bus.AWREADY, 0);
      begin
         int n;
         n = 0;
         while (!bus.AWREADY && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      check("late_awready", bus.AWREADY, 1);
      tick();
      bus.AWVALID = 1'b0;
      w_send(32'h1234_5678, 4'hF, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("b_hold", bus.BVALID, 1);
      end
      tick();
      bus.BREADY = 1'b1;
      wait_drain();
      check("both_write_mem", mem[14'h00C1], 32'h1234_5678);

      // address wrap at the top word
      rq.push_back('{8'h77, 32'hA5A5_0001, RESP_OKAY, 1'b0});
      rq.push_back('{8'h77, 32'h5A5A_0002, RESP_OKAY, 1'b1});
      ar_send(8'h77, 32'h0000_FFFC, 4'd1);
      wait_drain();

      // asynchronous reset in the middle of a write burst
      wc = wr_count;
      aw_send(8'h79, 32'h0000_0400, 4'd3);
      w_send(32'h0000_1111, 4'hF, 1'b0);
      bus.WDATA  = 32'h0000_2222;
      bus.WSTRB  = 4'hF;
      bus.WVALID = 1'b1;
      #1 rstn = 1'b0;
      #1 check_reset_vals("midrst");
      tick();
      tick();
      check("midrst_writes", wr_count - wc, 1);
      check("midrst_mem1", mem[14'h0101], 32'h0000_0000);
      bus.WVALID = 1'b0;
      tick();
      rstn = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
